operand_feeder: RTL and testbench

Upstream operand stage for the N×M systolic MAC array. It buffers an N×K A matrix and a K×M B matrix, written one word per cycle. It then streams A rows into the array's A lanes and B columns into the B lanes, one element per cycle per lane, gated by the array controller's per-lane enables (`A_in_en`, `B_in_en`). When every lane has streamed all K elements, it raises `finished`, which is consumed by the array controller.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/operand_feeder_if.sv | 33 +++
 rtl/feed_lane.sv | 66 ++++++
 rtl/operand_feeder.sv | 130 +++++++++++++
 tb/tb_operand_feeder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults and state encoding for the systolic MAC array operand path.
package systolic_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned N          = 3;
  localparam int unsigned M          = 3;
  localparam int unsigned K          = 3;
  localparam int unsigned ADDR_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feed_state_t;

endpackage

// File: rtl/operand_feeder_if.sv
// Buffer write port, streaming enables and lane outputs of the operand feeder.
interface operand_feeder_if #(
  parameter int unsigned DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int unsigned N          = systolic_pkg::N,
  parameter int unsigned M          = systolic_pkg::M,
  parameter int unsigned ADDR_W     = systolic_pkg::ADDR_W
);

  logic                             wr_en;
  logic                             wr_sel;
  logic [ADDR_W-1:0]                wr_row;
  logic [ADDR_W-1:0]                wr_col;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic                             start;
  logic [N-1:0]                     A_in_en;
  logic [M-1:0]                     B_in_en;
  logic [N-1:0][DATA_WIDTH-1:0]     A_out;
  logic [M-1:0][DATA_WIDTH-1:0]     B_out;
  logic                             busy;
  logic                             finished;
  logic                             wr_err;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start, A_in_en, B_in_en,
    input  A_out, B_out, busy, finished, wr_err
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start, A_in_en, B_in_en,
    output A_out, B_out, busy, finished, wr_err
  );

endinterface

// File: rtl/feed_lane.sv
// One operand lane: K-word buffer, saturating read pointer and registered output.
module feed_lane #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned K          = 3,
  parameter int unsigned PTR_W      = $clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [PTR_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clr_ptr,
  input  logic                  adv,
  input  logic                  show,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  exhausted
);

  localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

  logic [DATA_WIDTH-1:0] mem_q [K];
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_d;
  logic [DATA_WIDTH-1:0] rd_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_ptr) begin
      ptr_d = '0;
    end else if (adv && (ptr_q < PTR_W'(K))) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Flags the pointer value after this edge so DONE lands on the same edge.
  assign exhausted = (ptr_d == PTR_W'(K));

  // Output is pre-computed from next-cycle state; a same-edge write is forwarded.
  always_comb begin
    rd_d = '0;
    if (show && (ptr_d < PTR_W'(K))) begin
      if (we && (widx == ptr_d)) begin
        rd_d = wdata;
      end else begin
        rd_d = mem_q[ptr_d[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      data_out <= '0;
      for (int i = 0; i < int'(K); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      data_out <= rd_d;
      if (we) begin
        mem_q[widx[IDX_W-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Operand feeder top: FSM, buffer write decode, sticky write error and N+M lanes.
module operand_feeder #(
  parameter int unsigned DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int unsigned N          = systolic_pkg::N,
  parameter int unsigned M          = systolic_pkg::M,
  parameter int unsigned K          = systolic_pkg::K,
  parameter int unsigned ADDR_W     = systolic_pkg::ADDR_W
) (
  input logic             clk,
  input logic             rst,
  operand_feeder_if.slave bus
);

  import systolic_pkg::*;

  localparam int unsigned PTR_W = $clog2(K + 1);
  localparam int unsigned L     = N + M;

  feed_state_t state_q;
  feed_state_t state_d;
  logic        clr_ptr;
  logic        wr_ok;
  logic        all_exh;
  logic        stream_nxt;
  logic        streaming;
  logic        busy_q;
  logic        finished_q;
  logic        wr_err_q;
  logic [L-1:0] exh;
  logic [N-1:0][DATA_WIDTH-1:0] a_out;
  logic [M-1:0][DATA_WIDTH-1:0] b_out;

  assign streaming  = (state_q == STREAM);
  assign wr_ok      = bus.wr_en && !streaming;
  assign all_exh    = &exh;
  assign stream_nxt = (state_d == STREAM);

  // Next-state logic; start from IDLE or DONE rewinds every lane.
  always_comb begin
    state_d = state_q;
    clr_ptr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          clr_ptr = 1'b1;
        end
      end
      STREAM: begin
        if (all_exh) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = STREAM;
          clr_ptr = 1'b1;
        end else if (bus.wr_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d == STREAM);
      finished_q <= (state_d == DONE);
      if (bus.wr_en && streaming) begin
        wr_err_q <= 1'b1;
      end
    end
  end

  // A lanes: wr_row selects the lane, wr_col the element.
  for (genvar i = 0; i < int'(N); i++) begin : g_a
    localparam int unsigned LANE = i;
    logic             we;
    logic [PTR_W-1:0] widx;
    assign we   = wr_ok && !bus.wr_sel && (32'(bus.wr_row) == LANE) && (32'(bus.wr_col) < K);
    assign widx = PTR_W'(bus.wr_col);
    feed_lane #(.DATA_WIDTH(DATA_WIDTH), .K(K), .PTR_W(PTR_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .widx      (widx),
      .wdata     (bus.wr_data),
      .clr_ptr   (clr_ptr),
      .adv       (streaming && bus.A_in_en[i]),
      .show      (stream_nxt),
      .data_out  (a_out[i]),
      .exhausted (exh[i])
    );
  end

  // B lanes: wr_col selects the lane, wr_row the element.
  for (genvar j = 0; j < int'(M); j++) begin : g_b
    localparam int unsigned LANE = j;
    logic             we;
    logic [PTR_W-1:0] widx;
    assign we   = wr_ok && bus.wr_sel && (32'(bus.wr_col) == LANE) && (32'(bus.wr_row) < K);
    assign widx = PTR_W'(bus.wr_row);
    feed_lane #(.DATA_WIDTH(DATA_WIDTH), .K(K), .PTR_W(PTR_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .widx      (widx),
      .wdata     (bus.wr_data),
      .clr_ptr   (clr_ptr),
      .adv       (streaming && bus.B_in_en[j]),
      .show      (stream_nxt),
      .data_out  (b_out[j]),
      .exhausted (exh[N+j])
    );
  end

  assign bus.A_out    = a_out;
  assign bus.B_out    = b_out;
  assign bus.busy     = busy_q;
  assign bus.finished = finished_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder: directed scenarios plus random traffic vs a matrix-level model.
module tb_operand_feeder;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 3;
  localparam int unsigned M  = 3;
  localparam int unsigned K  = 3;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_feeder_if #(.DATA_WIDTH(DW), .N(N), .M(M), .ADDR_W(AW)) ifc ();

  operand_feeder #(.DATA_WIDTH(DW), .N(N), .M(M), .K(K), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: stored matrices, element counters per lane, and a phase (0 load, 1 streaming, 2 finished).
  logic [DW-1:0] ma [N][K];
  logic [DW-1:0] mb [M][K];
  int            pa [N];
  int            pb [M];
  int            phase;
  bit            m_err;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_a(input int i);
    return (phase == 1 && pa[i] < int'(K)) ? ma[i][pa[i]] : '0;
  endfunction

  function automatic logic [DW-1:0] exp_b(input int j);
    return (phase == 1 && pb[j] < int'(K)) ? mb[j][pb[j]] : '0;
  endfunction

  task automatic model_step();
    bit fire;
    bit all_done;
    int r;
    int c;
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin pa[i] = 0; for (int k = 0; k < int'(K); k++) ma[i][k] = '0; end
      for (int j = 0; j < int'(M); j++) begin pb[j] = 0; for (int k = 0; k < int'(K); k++) mb[j][k] = '0; end
      phase = 0;
      m_err = 1'b0;
    end else begin
      fire = ifc.wr_en && (phase != 1);
      if (ifc.wr_en && phase == 1) m_err = 1'b1;
      if (phase == 1) begin
        all_done = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
          if (ifc.A_in_en[i] && pa[i] < int'(K)) pa[i]++;
          if (pa[i] != int'(K)) all_done = 1'b0;
        end
        for (int j = 0; j < int'(M); j++) begin
          if (ifc.B_in_en[j] && pb[j] < int'(K)) pb[j]++;
          if (pb[j] != int'(K)) all_done = 1'b0;
        end
        if (all_done) phase = 2;
      end else if (ifc.start) begin
        phase = 1;
        for (int i = 0; i < int'(N); i++) pa[i] = 0;
        for (int j = 0; j < int'(M); j++) pb[j] = 0;
      end else if (phase == 2 && ifc.wr_en) begin
        phase = 0;
      end
      if (fire) begin
        r = int'(ifc.wr_row);
        c = int'(ifc.wr_col);
        if (!ifc.wr_sel && r < int'(N) && c < int'(K)) ma[r][c] = ifc.wr_data;
        if (ifc.wr_sel && r < int'(K) && c < int'(M)) mb[c][r] = ifc.wr_data;
      end
    end
  endtask

  // Every cycle: advance the model on the edge, then compare all outputs just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    for (int i = 0; i < int'(N); i++) chk($sformatf("cyc A_out[%0d]", i), ifc.A_out[i], exp_a(i));
    for (int j = 0; j < int'(M); j++) chk($sformatf("cyc B_out[%0d]", j), ifc.B_out[j], exp_b(j));
    chk("cyc busy", 32'(ifc.busy), 32'(phase == 1));
    chk("cyc finished", 32'(ifc.finished), 32'(phase == 2));
    chk("cyc wr_err", 32'(ifc.wr_err), 32'(m_err));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic sel, input logic [AW-1:0] row, input logic [AW-1:0] col,
                    input logic [DW-1:0] data);
    ifc.wr_en   = 1'b1;
    ifc.wr_sel  = sel;
    ifc.wr_row  = row;
    ifc.wr_col  = col;
    ifc.wr_data = data;
    tick();
    ifc.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 10 && !ifc.finished; n++) begin
      ifc.A_in_en = '1;
      ifc.B_in_en = '1;
      tick();
    end
    ifc.A_in_en = '0;
    ifc.B_in_en = '0;
    chk({tag, " drain finished"}, 32'(ifc.finished), 32'd1);
  endtask

  // Skewed wavefront over A = 1..9 and B = I; literal per-cycle expectations.
  task automatic skew_run(input string tag);
    int       ea [3][6];
    int       eb [3][6];
    logic [2:0] pat [6];
    ea = '{'{1, 2, 3, 0, 0, 0}, '{4, 4, 5, 6, 0, 0}, '{7, 7, 7, 8, 9, 0}};
    eb = '{'{1, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0}, '{0, 0, 0, 0, 1, 0}};
    pat = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("%s A%0d c%0d", tag, i, c), ifc.A_out[i], DW'(ea[i][c-1]));
        chk($sformatf("%s B%0d c%0d", tag, i, c), ifc.B_out[i], DW'(eb[i][c-1]));
      end
      chk($sformatf("%s finished c%0d", tag, c), 32'(ifc.finished), 32'(c == 6));
      chk($sformatf("%s busy c%0d", tag, c), 32'(ifc.busy), 32'(c != 6));
      ifc.A_in_en = pat[c-1];
      ifc.B_in_en = pat[c-1];
      tick();
    end
    ifc.A_in_en = '0;
    ifc.B_in_en = '0;
  endtask

  initial begin
    int sat [5];
    sat = '{1, 2, 3, 0, 0};
    rst         = 1'b1;
    ifc.wr_en   = 1'b0;
    ifc.wr_sel  = 1'b0;
    ifc.wr_row  = '0;
    ifc.wr_col  = '0;
    ifc.wr_data = '0;
    ifc.start   = 1'b0;
    ifc.A_in_en = '0;
    ifc.B_in_en = '0;

    // Reset held with arbitrary enables.
    tick();
    ifc.A_in_en = 3'($urandom);
    ifc.B_in_en = 3'($urandom);
    tick();
    ifc.A_in_en = 3'($urandom);
    tick();
    rst = 1'b0;
    chk("reset A_out[0]", ifc.A_out[0], '0);
    chk("reset B_out[2]", ifc.B_out[2], '0);
    chk("reset busy", 32'(ifc.busy), 32'd0);
    chk("reset finished", 32'(ifc.finished), 32'd0);
    ifc.A_in_en = '1;
    ifc.B_in_en = '1;
    tick();
    chk("idle en A_out[1]", ifc.A_out[1], '0);
    ifc.A_in_en = '0;
    ifc.B_in_en = '0;

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++)
        wr(1'b0, AW'(i), AW'(k), DW'(i * 3 + k + 1));
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        wr(1'b1, AW'(k), AW'(j), DW'(k == j));
    wr(1'b0, AW'(5), AW'(0), 32'hBAD);
    wr(1'b1, AW'(0), AW'(3), 32'hBAD);

    skew_run("skew");
    skew_run("restream");

    // Saturation on lane 0.
    pulse_start();
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("sat A0 c%0d", c), ifc.A_out[0], DW'(sat[c-1]));
      ifc.A_in_en = 3'b001;
      tick();
    end
    ifc.A_in_en = '0;
    chk("sat not finished", 32'(ifc.finished), 32'd0);
    drain("sat");

    // Illegal write during STREAM.
    pulse_start();
    ifc.wr_en   = 1'b1;
    ifc.wr_sel  = 1'b0;
    ifc.wr_row  = '0;
    ifc.wr_col  = '0;
    ifc.wr_data = 32'hDEAD;
    tick();
    ifc.wr_en   = 1'b0;
    chk("illegal wr_err", 32'(ifc.wr_err), 32'd1);
    chk("illegal A0 held", ifc.A_out[0], 32'd1);
    drain("illegal");
    pulse_start();
    chk("illegal restream A0", ifc.A_out[0], 32'd1);
    drain("illegal2");

    // Write in DONE returns to IDLE.
    wr(1'b0, AW'(0), AW'(0), 32'd1);
    chk("done wr finished", 32'(ifc.finished), 32'd0);
    chk("done wr busy", 32'(ifc.busy), 32'd0);

    // Reset after two enabled cycles; restream yields zeros.
    pulse_start();
    ifc.A_in_en = '1;
    ifc.B_in_en = '1;
    tick();
    tick();
    rst = 1'b1;
    ifc.A_in_en = '0;
    ifc.B_in_en = '0;
    tick();
    rst = 1'b0;
    chk("midrst A_out[0]", ifc.A_out[0], '0);
    chk("midrst busy", 32'(ifc.busy), 32'd0);
    chk("midrst wr_err", 32'(ifc.wr_err), 32'd0);
    pulse_start();
    chk("zero stream A_out[2]", ifc.A_out[2], '0);
    chk("zero stream busy", 32'(ifc.busy), 32'd1);
    drain("zero");

    // Random traffic including same-edge start+write, stray writes and resets.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 149) == 0);
      ifc.wr_en   = ($urandom_range(0, 3) == 0);
      ifc.wr_sel  = 1'($urandom);
      ifc.wr_row  = AW'($urandom_range(0, 4));
      ifc.wr_col  = AW'($urandom_range(0, 4));
      ifc.wr_data = $urandom;
      ifc.start   = ($urandom_range(0, 7) == 0);
      ifc.A_in_en = 3'($urandom);
      ifc.B_in_en = 3'($urandom);
      tick();
    end
    rst         = 1'b0;
    ifc.wr_en   = 1'b0;
    ifc.start   = 1'b0;
    ifc.A_in_en = '0;
    ifc.B_in_en = '0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
